// File: rtl/inst_fetch_if.sv
// inst_fetch_if: instruction-cache, redirect and decode handshake signals of the fetch stage.
// master is the fetch unit; slave is the environment around it.
interface inst_fetch_if;
   logic        inst_rreq;
   logic [31:0] inst_addr;
   logic        inst_valid;
   logic [31:0] inst_out;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        if_valid;
   logic [31:0] if_inst;
   logic [31:0] if_pc;
   logic        id_ready;
   modport master (
      output inst_rreq, inst_addr, if_valid, if_inst, if_pc,
      input  inst_valid, inst_out, redirect_valid, redirect_pc, id_ready
   );
   modport slave (
      input  inst_rreq, inst_addr, if_valid, if_inst, if_pc,
      output inst_valid, inst_out, redirect_valid, redirect_pc, id_ready
   );
endinterface

// File: rtl/inst_fetch.sv
// inst_fetch: single-outstanding instruction fetch FSM with a one-entry decode buffer
// and branch redirect handling (in-flight responses are discarded, latest target wins).
module inst_fetch #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input logic          cpu_clk,
   input logic          cpu_rstn,
   inst_fetch_if.master bus
);
   localparam logic [1:0] BOOT = 2'd0;
   localparam logic [1:0] REQ  = 2'd1;
   localparam logic [1:0] WAIT = 2'd2;
   localparam logic [1:0] HOLD = 2'd3;

   logic [1:0]  state;
   logic [31:0] req_pc;
   logic [31:0] tgt;
   logic        discard;
   logic [31:0] if_inst;
   logic [31:0] if_pc;
   logic [31:0] rpc;

   assign rpc           = {bus.redirect_pc[31:2], 2'b00};
   assign bus.inst_rreq = (state == REQ);
   assign bus.inst_addr = req_pc;
   assign bus.if_valid  = (state == HOLD);
   assign bus.if_inst   = if_inst;
   assign bus.if_pc     = if_pc;

   always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
      if (!cpu_rstn) begin
         state   <= BOOT;
         req_pc  <= RESET_PC;
         tgt     <= RESET_PC;
         discard <= 1'b0;
         if_inst <= 32'h0;
         if_pc   <= 32'h0;
      end else begin
         case (state)
            BOOT: begin
               state <= REQ;
               if (bus.redirect_valid) req_pc <= rpc;
            end
            REQ: begin
               state <= WAIT;
               if (bus.redirect_valid) begin
                  discard <= 1'b1;
                  tgt     <= rpc;
               end
            end
            WAIT: begin
               if (bus.inst_valid) begin
                  // a redirect arriving with the response also kills it
                  if (discard || bus.redirect_valid) begin
                     state   <= REQ;
                     discard <= 1'b0;
                     req_pc  <= bus.redirect_valid ? rpc : tgt;
                  end else begin
                     state   <= HOLD;
                     if_inst <= bus.inst_out;
                     if_pc   <= req_pc;
                  end
               end else if (bus.redirect_valid) begin
                  discard <= 1'b1;
                  tgt     <= rpc;
               end
            end
            HOLD: begin
               if (bus.redirect_valid) begin
                  state  <= REQ;
                  req_pc <= rpc;
               end else if (bus.id_ready) begin
                  state  <= REQ;
                  req_pc <= if_pc + 32'd4;
               end
            end
            default: state <= BOOT;
         endcase
      end
   end
endmodule

// File: doc/inst_fetch.md
INST_FETCH -- requirements
Module: inst_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, SHALL be the first fetch address after reset.
REQ-002 cpu_clk  input  1  SHALL be the sole clock; all state updates on its rising edge.
REQ-003 cpu_rstn  input  1  SHALL be the reset: asynchronous, active-low.
REQ-004 inst_rreq  output  1  SHALL be the fetch request pulse to the instruction cache.
REQ-005 inst_addr  output  32  SHALL be the fetch address to the instruction cache.
REQ-006 inst_valid  input  1  SHALL be the instruction-returned strobe from the instruction cache.
REQ-007 inst_out  input  32  SHALL be the returned instruction word, sampled only when inst_valid=1.
REQ-008 redirect_valid  input  1  SHALL be the branch/jump redirect strobe from the execute stage.
REQ-009 redirect_pc  input  32  SHALL be the redirect target, sampled only when redirect_valid=1.
REQ-010 if_valid  output  1  SHALL indicate that if_inst and if_pc hold a fetched instruction for decode.
REQ-011 if_inst  output  32  SHALL be the buffered instruction word.
REQ-012 if_pc  output  32  SHALL be the address of if_inst.
REQ-013 id_ready  input  1  SHALL indicate that decode accepts the instruction; transfer occurs when if_valid & id_ready.

Function
REQ-014 The FSM SHALL have four states: BOOT, REQ, WAIT, HOLD.
REQ-015 BOOT SHALL advance unconditionally to REQ on the first rising edge after reset release.
REQ-016 In REQ, inst_rreq SHALL be 1 for exactly that cycle and inst_addr SHALL equal req_pc; next state SHALL be WAIT.
REQ-017 inst_rreq SHALL be 0 in every state except REQ, giving exactly one pulse per fetch and at most one outstanding request.
REQ-018 inst_addr SHALL hold req_pc unchanged from the REQ cycle until the cycle inst_valid is received.
REQ-019 In WAIT with inst_valid=1 and no pending discard, the block SHALL capture inst_out into if_inst and req_pc into if_pc, then enter HOLD.
REQ-020 In HOLD, if_valid SHALL be 1; on id_ready=1 the next state SHALL be REQ with req_pc <= if_pc + 4.
REQ-021 if_valid SHALL be 1 only in HOLD; if_inst and if_pc SHALL hold their values when not in HOLD.
REQ-022 inst_valid SHALL be ignored in BOOT, REQ and HOLD.
REQ-023 PC arithmetic SHALL be 32-bit modulo: 32'hFFFF_FFFC + 4 = 32'h0000_0000.
REQ-024 redirect_pc[1:0] SHALL be forced to 2'b00 on capture.
REQ-025 A redirect in REQ or WAIT SHALL set a discard flag and store the target; the outstanding request still completes.
REQ-026 In WAIT with the discard flag set, the next inst_valid SHALL be dropped, the flag cleared, and the FSM SHALL enter REQ with req_pc = the stored target.
REQ-027 A redirect in the same cycle as inst_valid in WAIT SHALL discard that instruction and fetch the new target next.
REQ-028 With multiple redirects before inst_valid returns, the latest target SHALL win.
REQ-029 A redirect in HOLD SHALL drop if_valid on the next cycle and enter REQ with req_pc = the target, regardless of id_ready in the same cycle.
REQ-030 A redirect in BOOT SHALL replace RESET_PC as the first fetch address.

Reset
REQ-031 When cpu_rstn=0, state SHALL be BOOT, req_pc = RESET_PC, discard flag = 0, inst_rreq = 0, if_valid = 0, if_inst = 0, if_pc = 0, and inst_addr = RESET_PC.
REQ-032 Reset asserted mid-request SHALL abandon the request, and no inst_valid SHALL be consumed until a new REQ is issued.

Verification
REQ-033 Reset release, cache returning inst_out=32'h00000013 two cycles after the pulse, id_ready=1 -> one pulse at addr 0x0; if_valid=1 with if_pc=0x0 and if_inst=0x13; next pulse at addr 0x4.
REQ-034 id_ready=0 for 5 cycles in HOLD -> if_valid stays 1, if_inst and if_pc stable, no inst_rreq; release -> pulse at if_pc+4.
REQ-035 redirect_pc=0x100 one cycle after a pulse at 0x8 -> returned word for 0x8 dropped, if_valid never set for it, next pulse at 0x100.
REQ-036 redirect in HOLD (if_pc=0x20) together with id_ready=1, redirect_pc=0x43 -> if_valid=0 next cycle, next pulse at 0x40.
REQ-037 RESET_PC=32'hFFFF_FFFC, instruction accepted -> second pulse at 0x0.
REQ-038 cpu_rstn pulsed low while in WAIT -> outputs at reset values immediately, later inst_valid ignored, first post-reset pulse at RESET_PC.
